// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle for one SRAM-like port: address phase (req/addr_ok)
// and in-order data phase (data_ok/rdata).
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // master issues requests, slave accepts them and returns data
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between fetch (inst) and load/store (data) requesters,
// tracking outstanding transactions in issue order to route data_ok back.
module mem_req_arbiter #(
  parameter int unsigned MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  mem_req_arbiter_if.slave   inst,
  mem_req_arbiter_if.slave   data,
  mem_req_arbiter_if.master  mem
);

  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic               grant_data, grant_data_nxt;
  logic [MAX_OUT-1:0] id_fifo;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_data <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_data <= grant_data_nxt;
    end
  end

  // Gate uses the pre-pop count so a same-cycle data_ok never opens a slot early.
  always_comb begin
    state_nxt      = state;
    grant_data_nxt = grant_data;
    push           = 1'b0;
    case (state)
      IDLE: begin
        if ((inst.req || data.req) && (count < MAX_CNT)) begin
          state_nxt      = GRANT;
          grant_data_nxt = data.req;
        end
      end
      GRANT: begin
        if (mem.addr_ok) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.req      = (state == GRANT);
    mem.wr       = grant_data ? data.wr    : inst.wr;
    mem.size     = grant_data ? data.size  : inst.size;
    mem.wstrb    = grant_data ? data.wstrb : inst.wstrb;
    mem.addr     = grant_data ? data.addr  : inst.addr;
    mem.wdata    = grant_data ? data.wdata : inst.wdata;
    inst.addr_ok = push && !grant_data;
    data.addr_ok = push &&  grant_data;
  end

  assign pop          = mem.data_ok && (count != '0);
  assign head_data    = id_fifo[rd_ptr];
  assign inst.data_ok = pop && !head_data;
  assign data.data_ok = pop &&  head_data;
  assign inst.rdata   = resetn ? mem.rdata : '0;
  assign data.rdata   = resetn ? mem.rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_fifo <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
